// File: rtl/lab4_isa_pkg.sv
// lab4_isa_pkg
//   Shared ISA constants and controller state encoding for the lab4 multicycle CPU.
//   Contents: opcode/funct codes, FSM state enum, default reset PC and memory
//   timeout, and a small opcode classification helper.
package lab4_isa_pkg;

   localparam logic [5:0]  OP_R   = 6'h00;
   localparam logic [5:0]  OP_J   = 6'h02;
   localparam logic [5:0]  OP_BGT = 6'h07;
   localparam logic [5:0]  OP_LW  = 6'h23;
   localparam logic [5:0]  OP_SW  = 6'h2B;
   localparam logic [5:0]  FN_JR  = 6'h08;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [7:0]  MEM_TMO_DEF  = 8'd255;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   // lw and sw both take the ALU immediate path and visit MEM
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Single-port SRAM bus shared by instruction fetch and lw/sw data access.
//   mem_req      request, held until mem_ready
//   mem_we       1 = write, 0 = read (valid while mem_req)
//   mem_addr_sel 0 = address from pc, 1 = address from ALU result
//   mem_rdata    read data, valid with mem_ready
//   mem_ready    completion strobe for the current request
//   master = controller side, slave = memory side.
interface multicycle_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr_sel,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr_sel,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc
//   Combinational next-PC candidates for the multicycle controller.
//   pc          current program counter
//   instr_idx   ir[25:0] (jump index; low 16 bits are the branch immediate)
//   rs_val/rt_val register operands for the bgt compare
//   pc4         pc + 4 (wraps mod 2^32)
//   jump_tgt    {pc4[31:28], index, 2'b00}
//   branch_tgt  pc4 + sext(imm16) << 2 (wraps mod 2^32)
//   bgt_taken   signed(rs) > signed(rt); equal is not taken
module next_pc_calc (
   input  logic [31:0] pc,
   input  logic [25:0] instr_idx,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] pc4,
   output logic [31:0] jump_tgt,
   output logic [31:0] branch_tgt,
   output logic        bgt_taken
);

   logic [31:0] br_off;

   // Candidate targets and branch condition
   always_comb begin
      pc4        = pc + 32'd4;
      jump_tgt   = {pc4[31:28], instr_idx, 2'b00};
      br_off     = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
      branch_tgt = pc4 + br_off;
      bgt_taken  = $signed(rs_val) > $signed(rt_val);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle control FSM and PC sequencer: FETCH/DECODE/EXEC/MEM/WB, PC
//   ownership (j, jr, bgt, sequential), SRAM port arbitration and a per-request
//   memory timeout.
//   clk, reset   clock and synchronous active-high reset
//   mem          SRAM bus (master side)
//   rs_val/rt_val register-file read ports A/B
//   alu_src_imm  ALU B operand = sign-extended imm16
//   rf_we        register-file write pulse (WB)
//   rf_dst_rd    write $rd (R-type) instead of $rt
//   rf_from_mem  WB data from loaded word
//   ir, pc       instruction register, program counter
//   fault        sticky illegal-opcode / memory-timeout flag
module multicycle_ctrl
   import lab4_isa_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [7:0]  MEM_TMO  = MEM_TMO_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_ctrl_if.master        mem,
   input  logic [31:0]              rs_val,
   input  logic [31:0]              rt_val,
   output logic                     alu_src_imm,
   output logic                     rf_we,
   output logic                     rf_dst_rd,
   output logic                     rf_from_mem,
   output logic [31:0]              ir,
   output logic [31:0]              pc,
   output logic                     fault
);

   state_t      state, state_nxt;
   logic [31:0] pc_nxt, ir_nxt;
   logic        fault_nxt;
   logic [7:0]  tmo_cnt, tmo_nxt;
   logic [5:0]  op, op_nxt;
   logic        mem_done, mem_wait, tmo_hit;
   logic        req_nxt, we_nxt, sel_nxt, imm_nxt, rfwe_nxt, dst_nxt, frm_nxt;
   logic [31:0] pc4, jump_tgt, branch_tgt;
   logic        bgt_taken;

   next_pc_calc u_next_pc (
      .pc         (pc),
      .instr_idx  (ir[25:0]),
      .rs_val     (rs_val),
      .rt_val     (rt_val),
      .pc4        (pc4),
      .jump_tgt   (jump_tgt),
      .branch_tgt (branch_tgt),
      .bgt_taken  (bgt_taken)
   );

   // Next-state, next-PC, timeout and next-cycle output decode
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      fault_nxt = fault;
      op        = ir[31:26];
      // mem_ready only counts against a request we are actually driving
      mem_done  = mem.mem_req & mem.mem_ready;
      mem_wait  = mem.mem_req & ~mem.mem_ready;
      tmo_hit   = mem_wait && (tmo_cnt == (MEM_TMO - 8'd1));
      tmo_nxt   = mem_wait ? (tmo_cnt + 8'd1) : 8'd0;

      case (state)
         FETCH: begin
            if (tmo_hit) begin
               fault_nxt = 1'b1;
               state_nxt = HALT;
            end else if (mem_done) begin
               ir_nxt    = mem.mem_rdata;
               state_nxt = DECODE;
            end else begin
               state_nxt = FETCH;
            end
         end
         DECODE: begin
            case (op)
               OP_J: begin
                  pc_nxt    = jump_tgt;
                  state_nxt = FETCH;
               end
               OP_BGT: begin
                  pc_nxt    = bgt_taken ? branch_tgt : pc4;
                  state_nxt = FETCH;
               end
               OP_R: begin
                  if (ir[5:0] == FN_JR) begin
                     pc_nxt    = rs_val;
                     state_nxt = FETCH;
                  end else begin
                     state_nxt = EXEC;
                  end
               end
               OP_LW, OP_SW: state_nxt = EXEC;
               default: begin
                  fault_nxt = 1'b1;
                  state_nxt = HALT;
               end
            endcase
         end
         EXEC: state_nxt = is_mem_op(op) ? MEM : WB;
         MEM: begin
            if (tmo_hit) begin
               fault_nxt = 1'b1;
               state_nxt = HALT;
            end else if (mem_done && (op == OP_SW)) begin
               pc_nxt    = pc4;
               state_nxt = FETCH;
            end else if (mem_done) begin
               // loaded word is captured by the datapath on this mem_ready
               state_nxt = WB;
            end else begin
               state_nxt = MEM;
            end
         end
         WB: begin
            pc_nxt    = pc4;
            state_nxt = FETCH;
         end
         HALT: state_nxt = HALT;
         default: begin
            fault_nxt = 1'b1;
            state_nxt = HALT;
         end
      endcase

      // Outputs are registered, so decode them from the state being entered
      // and the instruction that will be in ir then.
      op_nxt   = ir_nxt[31:26];
      req_nxt  = (state_nxt == FETCH) || (state_nxt == MEM);
      sel_nxt  = (state_nxt == MEM);
      we_nxt   = (state_nxt == MEM) && (op_nxt == OP_SW);
      imm_nxt  = (state_nxt inside {DECODE, EXEC, MEM}) && is_mem_op(op_nxt);
      rfwe_nxt = (state_nxt == WB);
      dst_nxt  = (state_nxt == WB) && (op_nxt == OP_R);
      frm_nxt  = (state_nxt == WB) && (op_nxt == OP_LW);
   end

   // State, PC, IR, fault, timeout counter and registered strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= FETCH;
         pc               <= RESET_PC;
         ir               <= 32'h0000_0000;
         fault            <= 1'b0;
         tmo_cnt          <= 8'd0;
         mem.mem_req      <= 1'b0;
         mem.mem_we       <= 1'b0;
         mem.mem_addr_sel <= 1'b0;
         alu_src_imm      <= 1'b0;
         rf_we            <= 1'b0;
         rf_dst_rd        <= 1'b0;
         rf_from_mem      <= 1'b0;
      end else begin
         state            <= state_nxt;
         pc               <= pc_nxt;
         ir               <= ir_nxt;
         fault            <= fault_nxt;
         tmo_cnt          <= tmo_nxt;
         mem.mem_req      <= req_nxt;
         mem.mem_we       <= we_nxt;
         mem.mem_addr_sel <= sel_nxt;
         alu_src_imm      <= imm_nxt;
         rf_we            <= rfwe_nxt;
         rf_dst_rd        <= dst_nxt;
         rf_from_mem      <= frm_nxt;
      end
   end

endmodule
